ppu_pixel_fifo: RTL and testbench



---
 rtl/ppu_pixel_fifo_if.sv | 30 +++
 rtl/ppu_pixel_fifo.sv | 90 +++++++++
 tb/tb_ppu_pixel_fifo.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ppu_pixel_fifo_if.sv
// Handshake/status bundle between the PPU pixel pipeline, the VGA reader and the pixel FIFO.
// slave = FIFO side, master = producer/consumer side.
interface ppu_pixel_fifo_if #(
  parameter int ADDR_W = 9
);
  logic              flush;
  logic              wr_en;
  logic [5:0]        wr_data;
  logic              rd_en;
  logic [5:0]        rd_data;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic              clr_flags;
  logic [15:0]       ovf_cnt;
  logic [15:0]       udf_cnt;

  modport slave (
    input  flush, wr_en, wr_data, rd_en, clr_flags,
    output rd_data, empty, full, almost_full, count, overflow, underflow, ovf_cnt, udf_cnt
  );

  modport master (
    output flush, wr_en, wr_data, rd_en, clr_flags,
    input  rd_data, empty, full, almost_full, count, overflow, underflow, ovf_cnt, udf_cnt
  );
endinterface

// File: rtl/ppu_pixel_fifo.sv
// First-word-fall-through palette-index FIFO between PPU and VGA, with sticky error flags and flush.
// Define PPU_PIXEL_FIFO_ERRCNT_EN to build the saturating overflow/underflow event counters.
module ppu_pixel_fifo #(
  parameter int         DEPTH         = 512,
  parameter int         ADDR_W        = 9,
  parameter int         AF_THRESH     = 448,
  parameter logic [5:0] UNDERFLOW_IDX = 6'h0F
) (
  input  logic             clk,
  input  logic             reset,
  ppu_pixel_fifo_if.slave  bus
);

  logic [5:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              empty, full, pop, push, ovf_evt, udf_evt;
  logic              overflow, underflow;

  assign empty = (cnt == '0);
  assign full  = (cnt == (ADDR_W+1)'(DEPTH));

  // A flush cycle swallows both strobes, so none of these fire then.
  assign pop     = bus.rd_en & ~empty & ~bus.flush;
  assign push    = bus.wr_en & (~full | pop) & ~bus.flush;
  assign ovf_evt = bus.wr_en & full & ~pop & ~bus.flush;
  assign udf_evt = bus.rd_en & empty & ~bus.flush;

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Set wins over clr_flags; flush leaves the sticky flags alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt | (overflow  & ~bus.clr_flags);
      underflow <= udf_evt | (underflow & ~bus.clr_flags);
    end
  end

`ifdef PPU_PIXEL_FIFO_ERRCNT_EN
  logic [15:0] ovf_q, udf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      if (ovf_evt)            ovf_q <= bus.clr_flags ? 16'd1 : (&ovf_q ? ovf_q : ovf_q + 1'b1);
      else if (bus.clr_flags) ovf_q <= '0;
      if (udf_evt)            udf_q <= bus.clr_flags ? 16'd1 : (&udf_q ? udf_q : udf_q + 1'b1);
      else if (bus.clr_flags) udf_q <= '0;
    end
  end

  assign bus.ovf_cnt = ovf_q;
  assign bus.udf_cnt = udf_q;
`else
  assign bus.ovf_cnt = '0;
  assign bus.udf_cnt = '0;
`endif

  assign bus.rd_data     = empty ? UNDERFLOW_IDX : mem[rd_ptr];
  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.almost_full = (cnt >= (ADDR_W+1)'(AF_THRESH));
  assign bus.count       = cnt;
  assign bus.overflow    = overflow;
  assign bus.underflow   = underflow;

endmodule

// File: tb/tb_ppu_pixel_fifo.sv
// Scoreboard bench for ppu_pixel_fifo: a queue model tracks contents, flags and counters every cycle.
module tb_ppu_pixel_fifo;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ppu_pixel_fifo_if #(.ADDR_W(9)) bus();
  ppu_pixel_fifo dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  logic [5:0]  q[$];
  logic        m_ovf, m_udf;
  logic [15:0] m_oc, m_uc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    int sz = q.size();
    chk("count", 32'(bus.count), 32'(sz));
    chk("empty", 32'(bus.empty), 32'(sz == 0));
    chk("full", 32'(bus.full), 32'(sz == 512));
    chk("almost_full", 32'(bus.almost_full), 32'(sz >= 448));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_udf));
    chk("rd_data", 32'(bus.rd_data), (sz != 0) ? 32'(q[0]) : 32'h0F);
    chk("ovf_cnt", 32'(bus.ovf_cnt), 32'(m_oc));
    chk("udf_cnt", 32'(bus.udf_cnt), 32'(m_uc));
  endtask

  function automatic logic [15:0] bump(input logic [15:0] c, input logic ev, input logic clr);
    if (ev)  return clr ? 16'd1 : ((c == 16'hFFFF) ? c : c + 16'd1);
    if (clr) return 16'd0;
    return c;
  endfunction

  task automatic cyc(input logic wr, input logic [5:0] wd, input logic rd,
                     input logic fl, input logic clr);
    int   sz;
    logic pop, push, ovf, udf;
    bus.wr_en = wr; bus.wr_data = wd; bus.rd_en = rd;
    bus.flush = fl; bus.clr_flags = clr;
    #1;
    sz   = q.size();
    pop  = rd && sz != 0 && !fl;
    push = wr && (sz < 512 || pop) && !fl;
    ovf  = wr && sz == 512 && !pop && !fl;
    udf  = rd && sz == 0 && !fl;
    if (pop) chk("pop_data", 32'(bus.rd_data), 32'(q[0]));
    if (fl) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(wd);
    end
    m_ovf = ovf | (m_ovf & ~clr);
    m_udf = udf | (m_udf & ~clr);
`ifdef PPU_PIXEL_FIFO_ERRCNT_EN
    m_oc = bump(m_oc, ovf, clr);
    m_uc = bump(m_uc, udf, clr);
`endif
    @(posedge clk); #1;
    check_state();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 6'h15;
    bus.flush = 1'b0; bus.clr_flags = 1'b0;
    @(posedge clk); #1;
    q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_oc = '0; m_uc = '0;
    check_state();
    reset = 1'b0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = '0;
    bus.flush = 1'b0; bus.clr_flags = 1'b0;
    m_ovf = 1'b0; m_udf = 1'b0; m_oc = '0; m_uc = '0;
    @(posedge clk); #1;
    do_reset();

    // Three writes, no reads: head is the first one.
    cyc(1, 6'h01, 0, 0, 0);
    chk("empty_after_1st_wr", 32'(bus.empty), 32'd0);
    cyc(1, 6'h02, 0, 0, 0);
    cyc(1, 6'h03, 0, 0, 0);
    chk("head_after_3", 32'(bus.rd_data), 32'h01);

    // Drain and confirm fall-back index with no underflow.
    for (int i = 0; i < 3; i++) cyc(0, 6'h00, 1, 0, 0);
    chk("drained_rd_data", 32'(bus.rd_data), 32'h0F);
    chk("no_underflow", 32'(bus.underflow), 32'd0);

    // Fill to 512, watching almost_full threshold.
    for (int i = 0; i < 512; i++) begin
      cyc(1, 6'(i), 0, 0, 0);
      if (i == 446) chk("af_below_448", 32'(bus.almost_full), 32'd0);
      if (i == 447) chk("af_at_448", 32'(bus.almost_full), 32'd1);
    end
    chk("full_at_512", 32'(bus.full), 32'd1);
    cyc(1, 6'h3F, 0, 0, 0);
    chk("ovf_drop_head", 32'(bus.rd_data), 32'h00);
    chk("ovf_set", 32'(bus.overflow), 32'd1);

    // Simultaneous push/pop at full, then drain everything; last out must be 0x2A.
    cyc(1, 6'h2A, 1, 0, 0);
    chk("full_rw_count", 32'(bus.count), 32'd512);
    for (int i = 0; i < 511; i++) cyc(0, 6'h00, 1, 0, 0);
    chk("entry_512", 32'(bus.rd_data), 32'h2A);
    cyc(0, 6'h00, 1, 0, 0);

    // Read+write at empty: underflow set and the write lands.
    cyc(1, 6'h30, 1, 0, 0);
    chk("udf_wr_data", 32'(bus.rd_data), 32'h30);
    chk("udf_set", 32'(bus.underflow), 32'd1);
    cyc(0, 6'h00, 0, 0, 1);
    chk("udf_cleared", 32'(bus.underflow), 32'd0);

    // Clear racing a new underflow event: set wins.
    for (int i = 0; i < 99; i++) cyc(1, 6'(i + 7), 0, 0, 0);
    cyc(0, 6'h00, 0, 1, 0);
    cyc(0, 6'h00, 1, 0, 1);
    chk("set_wins_clr", 32'(bus.underflow), 32'd1);

    // Flush at count 100 with both strobes high.
    for (int i = 0; i < 100; i++) cyc(1, 6'(i), 0, 0, 0);
    chk("pre_flush_count", 32'(bus.count), 32'd100);
    cyc(1, 6'h11, 1, 1, 0);
    chk("flush_empty", 32'(bus.empty), 32'd1);
    chk("flush_keeps_udf", 32'(bus.underflow), 32'd1);

    // Random traffic including occasional flush/clear.
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 99) < 55), 6'($urandom), 1'($urandom_range(0, 99) < 50),
          1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 3));

    for (int i = 0; i < 20; i++) cyc(1, 6'(i + 3), 0, 0, 0);
    do_reset();
    chk("reset_rd_data", 32'(bus.rd_data), 32'h0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
